// File: rtl/mc10141_shift_reg.sv
// 4-bit universal shift register (load / shift toward bit 0 / shift toward bit 3 / hold), bit 0 is MSB.
// Latency: one rising clk edge from inputs to q; q driven straight from flops.
// Backpressure: none; a new mode and data are accepted on every edge.
module mc10141_shift_reg (
    input  logic d0In,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d3In,
    input  logic s1,
    input  logic s0,
    input  logic clk,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    input  logic reset
);

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_SHIFTL = 2'b01,
        MODE_SHIFTR = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Index i of the register holds q<i>; index 0 is the leftmost/MSB position.
    logic [0:3] shreg_q;
    logic [0:3] shreg_d;
    mode_e      mode;

    assign mode = mode_e'({s1, s0});

    // Next-state selection for the four operating modes.
    always_comb begin
        shreg_d = shreg_q;
        case (mode)
            MODE_LOAD:   shreg_d = {d0, d1, d2, d3};
            MODE_SHIFTL: shreg_d = {d0In, shreg_q[0:2]};
            MODE_SHIFTR: shreg_d = {shreg_q[1:3], d3In};
            MODE_HOLD:   shreg_d = shreg_q;
            default:     shreg_d = shreg_q;
        endcase
    end

    // State register; synchronous reset overrides every mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q0 = shreg_q[0];
    assign q1 = shreg_q[1];
    assign q2 = shreg_q[2];
    assign q3 = shreg_q[3];

endmodule

// File: tb/tb_mc10141_shift_reg.sv
// Self-checking bench for mc10141_shift_reg: vector table plus between-edge stability sequence.
// Inputs driven on the falling edge, outputs compared 1ns after the rising edge.
// Expected values queued when stimulus is driven and popped when the edge has produced output.
module tb_mc10141_shift_reg;

    logic clk = 1'b0;
    logic reset;
    logic d0In, d3In, s1, s0;
    logic d0, d1, d2, d3;
    logic q0, q1, q2, q3;

    int errors = 0;
    int checks = 0;

    // Bit vectors below are written q0q1q2q3 / d0d1d2d3 (bit [3] is position 0).
    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [3:0] d;
        logic       d0in;
        logic       d3in;
        logic [3:0] exp;
    } vec_t;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] SHL = 2'b01;
    localparam logic [1:0] SHR = 2'b10;
    localparam logic [1:0] HLD = 2'b11;

    vec_t       vecs[$];
    logic [3:0] sb[$];

    mc10141_shift_reg dut (
        .d0In (d0In),
        .d0   (d0),
        .d1   (d1),
        .d2   (d2),
        .d3   (d3),
        .d3In (d3In),
        .s1   (s1),
        .s0   (s0),
        .clk  (clk),
        .q0   (q0),
        .q1   (q1),
        .q2   (q2),
        .q3   (q3),
        .reset(reset)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [1:0] m, input logic [3:0] d,
                                input logic di0, input logic di3, input logic [3:0] e);
        vec_t v;
        v.rst = r; v.mode = m; v.d = d; v.d0in = di0; v.d3in = di3; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic [1:0] m, input logic [3:0] d,
                         input logic di0, input logic di3);
        reset = r;
        {s1, s0} = m;
        {d0, d1, d2, d3} = d;
        d0In = di0;
        d3In = di3;
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {q0, q1, q2, q3};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: q0..q3 got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] hold_val;
        drive(1'b1, LD, 4'b1010, 1'b1, 1'b1);

        // Reset state
        add(1, LD,  4'b1010, 1, 1, 4'b0000);
        // Parallel load 1111 under all serial combinations
        add(0, LD,  4'b1111, 0, 0, 4'b1111);
        add(0, LD,  4'b1111, 0, 1, 4'b1111);
        add(0, LD,  4'b1111, 1, 0, 4'b1111);
        add(0, LD,  4'b1111, 1, 1, 4'b1111);
        add(0, LD,  4'b1010, 1, 0, 4'b1010);
        add(0, LD,  4'b0101, 0, 1, 4'b0101);
        add(0, LD,  4'b0000, 1, 1, 4'b0000);
        // Shift toward bit 0 with garbage on d / d0In
        add(0, SHR, 4'b1101, 0, 1, 4'b0001);
        add(0, SHR, 4'b0110, 1, 1, 4'b0011);
        add(0, SHR, 4'b1011, 0, 1, 4'b0111);
        add(0, SHR, 4'b0100, 1, 1, 4'b1111);
        add(0, SHR, 4'b1001, 0, 1, 4'b1111);
        add(0, SHR, 4'b0111, 1, 0, 4'b1110);
        add(0, SHR, 4'b1110, 0, 0, 4'b1100);
        add(0, SHR, 4'b0011, 1, 0, 4'b1000);
        add(0, SHR, 4'b1111, 1, 0, 4'b0000);
        add(0, SHR, 4'b1000, 0, 0, 4'b0000);
        // Shift toward bit 3 with garbage on d / d3In
        add(0, SHL, 4'b0110, 1, 0, 4'b1000);
        add(0, SHL, 4'b1001, 1, 1, 4'b1100);
        add(0, SHL, 4'b0011, 1, 0, 4'b1110);
        add(0, SHL, 4'b1100, 1, 1, 4'b1111);
        add(0, SHL, 4'b0101, 0, 1, 4'b0111);
        add(0, SHL, 4'b1111, 0, 0, 4'b0011);
        add(0, SHL, 4'b1010, 0, 1, 4'b0001);
        add(0, SHL, 4'b0001, 0, 1, 4'b0000);
        // Hold
        add(0, LD,  4'b1010, 0, 0, 4'b1010);
        add(0, HLD, 4'b1111, 1, 0, 4'b1010);
        add(0, HLD, 4'b0000, 0, 1, 4'b1010);
        add(0, HLD, 4'b0101, 1, 1, 4'b1010);
        add(0, HLD, 4'b1111, 0, 0, 4'b1010);
        add(0, LD,  4'b0101, 1, 1, 4'b0101);
        add(0, LD,  4'b1010, 0, 0, 4'b1010);
        // Reset priority and release
        add(0, LD,  4'b1111, 0, 0, 4'b1111);
        add(1, LD,  4'b1111, 1, 1, 4'b0000);
        add(1, SHR, 4'b1111, 1, 1, 4'b0000);
        add(1, SHR, 4'b0110, 0, 1, 4'b0000);
        add(0, SHR, 4'b1111, 1, 1, 4'b0001);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].mode, vecs[i].d, vecs[i].d0in, vecs[i].d3in);
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), sb.pop_front());
        end

        // Stability between edges: state is 0001; wiggle everything during the low phase.
        hold_val = 4'b0001;
        @(negedge clk);
        drive(0, LD, 4'b1111, 1, 1);
        #1 check("low_phase_load1111", hold_val);
        drive(0, SHL, 4'b0000, 1, 0);
        #1 check("low_phase_shl", hold_val);
        drive(0, SHR, 4'b1010, 0, 1);
        #1 check("low_phase_shr", hold_val);
        drive(0, LD, 4'b0110, 0, 0);
        sb.push_back(4'b0110);
        #1 check("low_phase_final", hold_val);
        @(posedge clk);
        #1 check("edge_after_wiggle", sb.pop_front());
        // High phase after the edge must also be quiet while inputs move.
        drive(0, SHL, 4'b1001, 1, 1);
        #2 check("high_phase_stable", 4'b0110);
        @(negedge clk);
        #1 check("falling_edge_stable", 4'b0110);
        @(posedge clk);
        #1 check("shl_after_stability", 4'b1011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
